// File: rtl/dial_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dial_pkg
// Brief    : Shared state encoding and spinner word field positions for the dial.
// Revision : 1.0 - initial release
// ============================================================================
package dial_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } dial_state_e;

    localparam int SPIN_TOGGLE_BIT = 8;
    localparam int SPIN_DELTA_MSB  = 7;

endpackage
`default_nettype wire

// File: rtl/dial_edge.sv
`default_nettype none
// ============================================================================
// Module   : dial_edge
// Brief    : Registered edge detector, rising-only or any-edge.
// Revision : 1.0 - initial release
// ============================================================================
module dial_edge #(
    parameter bit ANY_EDGE = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sig,
    output logic pulse
);

    logic sig_q;
    logic sig_d;

    always_comb begin
        sig_d = sig;
    end

    // The copy tracks the input during reset too, so release never fakes an edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sig_q <= sig;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign pulse = ANY_EDGE ? (sig ^ sig_q) : (sig & ~sig_q);

endmodule
`default_nettype wire

// File: rtl/dial_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : dial_accumulator
// Brief    : Digital/spinner rotation accumulator, angle published per frame.
//            Spinner path enabled by DIAL_SPIN_INPUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dial_accumulator
    import dial_pkg::*;
#(
    parameter int W     = 4,
    parameter int FRAC  = 2,
    parameter int RATE  = 8,
    parameter int DELAY = 16
) (
    input  logic         clk_sys,
    input  logic         reset_n,
    input  logic         minus,
    input  logic         plus,
    input  logic         fast,
    input  logic [8:0]   spin_in,
    input  logic         strobe,
    output logic [W-1:0] angle,
    output logic         frame_tick
);

    localparam int ACC_W   = W + FRAC;
    localparam int MAX_CNT = (DELAY > RATE) ? DELAY : RATE;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [ACC_W-1:0] STEP = ACC_W'(2 ** FRAC);

    dial_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sign_q, sign_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [W-1:0]     angle_q, angle_d;
    logic             frame_tick_q, frame_tick_d;

    logic             w_strobe_rise;
    logic             w_dir;
    logic             w_step;
    logic [ACC_W-1:0] w_dig_add;
    logic [ACC_W-1:0] w_spin_add;

    dial_edge #(
        .ANY_EDGE (1'b0)
    ) u_strobe_edge (
        .clk     (clk_sys),
        .reset_n (reset_n),
        .sig     (strobe),
        .pulse   (w_strobe_rise)
    );

`ifdef DIAL_SPIN_INPUT_EN
    logic             w_spin_toggle;
    logic [ACC_W-1:0] w_spin_delta;

    dial_edge #(
        .ANY_EDGE (1'b1)
    ) u_spin_edge (
        .clk     (clk_sys),
        .reset_n (reset_n),
        .sig     (spin_in[SPIN_TOGGLE_BIT]),
        .pulse   (w_spin_toggle)
    );

    // Signed size cast: sign-extends for wide accumulators, wraps for narrow ones.
    assign w_spin_delta = ACC_W'($signed(spin_in[SPIN_DELTA_MSB:0]));
    assign w_spin_add   = w_spin_toggle ? w_spin_delta : '0;
`else
    logic w_spin_unused;
    assign w_spin_unused = ^spin_in;
    assign w_spin_add    = '0;
`endif

    assign w_dir = plus ^ minus;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        w_step  = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_dir) begin
                    w_step  = 1'b1;
                    cnt_d   = CNT_W'(DELAY);
                    sign_d  = plus;
                    state_d = HOLD;
                end
            end
            HOLD, REPEAT: begin
                // A released or reversed press drops back so the next press steps at once.
                if (!w_dir || (plus != sign_q)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (w_strobe_rise) begin
                    if (cnt_q <= CNT_W'(1)) begin
                        w_step  = 1'b1;
                        cnt_d   = fast ? CNT_W'(1) : CNT_W'(RATE);
                        state_d = REPEAT;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        w_dig_add    = '0;
        if (w_step) begin
            w_dig_add = plus ? STEP : (ACC_W'(0) - STEP);
        end
        acc_d        = acc_q + w_dig_add + w_spin_add;
        frame_tick_d = w_strobe_rise;
        angle_d      = w_strobe_rise ? acc_q[ACC_W-1:FRAC] : angle_q;
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sign_q       <= 1'b0;
            acc_q        <= '0;
            angle_q      <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sign_q       <= sign_d;
            acc_q        <= acc_d;
            angle_q      <= angle_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign angle      = angle_q;
    assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_dial_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_dial_accumulator
// Brief    : Directed self-checking bench for dial_accumulator (W=4, FRAC=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dial_accumulator;

    localparam int W     = 4;
    localparam int FRAC  = 2;
    localparam int RATE  = 8;
    localparam int DELAY = 16;

    logic         clk_sys = 1'b0;
    logic         reset_n = 1'b0;
    logic         minus   = 1'b0;
    logic         plus    = 1'b0;
    logic         fast    = 1'b0;
    logic [8:0]   spin_in = 9'h000;
    logic         strobe  = 1'b0;
    logic [W-1:0] angle;
    logic         frame_tick;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] ang;
    logic         ft_hi;
    logic         ft_lo;
    int           exp_ang;

    dial_accumulator #(
        .W     (W),
        .FRAC  (FRAC),
        .RATE  (RATE),
        .DELAY (DELAY)
    ) u_dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .minus      (minus),
        .plus       (plus),
        .fast       (fast),
        .spin_in    (spin_in),
        .strobe     (strobe),
        .angle      (angle),
        .frame_tick (frame_tick)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick_clk();
        @(posedge clk_sys);
        #1;
    endtask

    // One strobe period; samples angle and frame_tick on the two falling edges after the rise.
    task automatic do_frame(output logic [W-1:0] a, output logic hi, output logic lo);
        strobe = 1'b1;
        @(posedge clk_sys);
        @(negedge clk_sys);
        a  = angle;
        hi = frame_tick;
        @(negedge clk_sys);
        lo = frame_tick;
        @(posedge clk_sys);
        #1;
        strobe = 1'b0;
        tick_clk();
        tick_clk();
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        tick_clk();
        tick_clk();
        check_eq("reset_angle", int'(angle), 0);
        check_eq("reset_frame_tick", int'(frame_tick), 0);
        reset_n = 1'b1;
    endtask

    task automatic spin_toggle(input logic [7:0] delta);
        spin_in = {~spin_in[8], delta};
        tick_clk();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        apply_reset();

        // Idle frames: angle stays 0, frame_tick exactly one cycle wide
        for (int k = 0; k < 3; k++) begin
            do_frame(ang, ft_hi, ft_lo);
            check_eq("idle_angle", int'(ang), 0);
            check_eq("tick_high", int'(ft_hi), 1);
            check_eq("tick_low", int'(ft_lo), 0);
        end

        // Single-cycle plus pulse; angle must hold until the next frame
        plus = 1'b1;
        tick_clk();
        plus = 1'b0;
        tick_clk();
        check_eq("angle_holds", int'(angle), 0);
        do_frame(ang, ft_hi, ft_lo);
        check_eq("plus_pulse", int'(ang), 1);

        // Held plus: fresh step, first repeat after 16 ticks, then every 8
        plus = 1'b1;
        tick_clk();
        for (int k = 1; k <= 33; k++) begin
            do_frame(ang, ft_hi, ft_lo);
            exp_ang = (k <= 16) ? 2 : (k <= 24) ? 3 : (k <= 32) ? 4 : 5;
            check_eq($sformatf("plus_hold_f%0d", k), int'(ang), exp_ang);
        end
        plus = 1'b0;
        tick_clk();

        // Held minus with fast: wrap to 15, then one step per frame after the delay
        apply_reset();
        minus = 1'b1;
        fast  = 1'b1;
        tick_clk();
        for (int k = 1; k <= 20; k++) begin
            do_frame(ang, ft_hi, ft_lo);
            exp_ang = (k <= 16) ? 15 : 15 - (k - 16);
            check_eq($sformatf("minus_fast_f%0d", k), int'(ang), exp_ang);
        end
        minus = 1'b0;
        fast  = 1'b0;
        tick_clk();

`ifdef DIAL_SPIN_INPUT_EN
        // Spinner deltas
        apply_reset();
        spin_toggle(8'h06);
        tick_clk();
        spin_toggle(8'h06);
        do_frame(ang, ft_hi, ft_lo);
        check_eq("spin_plus12", int'(ang), 3);

        // Toggle bit flipped while in reset must not count as a sample
        spin_in = {~spin_in[8], 8'h3C};
        apply_reset();
        tick_clk();
        do_frame(ang, ft_hi, ft_lo);
        check_eq("spin_no_false_edge", int'(ang), 0);

        spin_toggle(8'h80);
        do_frame(ang, ft_hi, ft_lo);
        check_eq("spin_minus128", int'(ang), 0);
        spin_toggle(8'hFF);
        do_frame(ang, ft_hi, ft_lo);
        check_eq("spin_minus1_wrap", int'(ang), 15);
        spin_toggle(8'h05);
        do_frame(ang, ft_hi, ft_lo);
        check_eq("spin_plus5_wrap", int'(ang), 1);
`endif

        // Both buttons held: no digital motion
        apply_reset();
        plus  = 1'b1;
        minus = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            do_frame(ang, ft_hi, ft_lo);
            check_eq($sformatf("both_f%0d", k), int'(ang), 0);
        end
        plus  = 1'b0;
        minus = 1'b0;
        tick_clk();

        // Digital step and spinner +4 landing in the same cycle
        plus    = 1'b1;
        spin_in = {~spin_in[8], 8'h04};
        tick_clk();
        plus = 1'b0;
        tick_clk();
        do_frame(ang, ft_hi, ft_lo);
`ifdef DIAL_SPIN_INPUT_EN
        check_eq("step_plus_spin", int'(ang), 2);
`else
        check_eq("step_spin_ignored", int'(ang), 1);
`endif

        // Reset during REPEAT with plus held, then fresh press after release
        apply_reset();
        plus = 1'b1;
        tick_clk();
        for (int k = 1; k <= 17; k++) begin
            do_frame(ang, ft_hi, ft_lo);
        end
        check_eq("repeat_before_reset", int'(ang), 2);
        apply_reset();
        tick_clk();
        do_frame(ang, ft_hi, ft_lo);
        check_eq("press_after_reset", int'(ang), 1);
        plus = 1'b0;
        tick_clk();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dial_accumulator.md
# dial_accumulator

Converts player rotation inputs into a wrapping dial angle for the game's input port. Inputs are digital left/right from keyboard or joystick, the fast-turn button, and the packed spinner word from the HPS. It accumulates motion into a fractional position register and republishes the integer angle once per video frame on the vertical-sync strobe. It sits between the input-merge logic and the game core's input-port nibble that carries the dial.

## Interface
Parameters:
- W, 4, width of published angle
- FRAC, 2, fractional bits of accumulator (spinner sensitivity divisor 2^FRAC)
- RATE, 8, frames between slow repeat steps of held digital input
- DELAY, 16, frames from press to first repeat step

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- minus  in  1  digital rotate counter-clockwise (level)
- plus  in  1  digital rotate clockwise (level)
- fast  in  1  fast-turn modifier
- spin_in  in  9  HPS spinner word: [7:0] signed delta, [8] toggles per new sample
- strobe  in  1  vertical sync (level); rising edge = frame tick
- angle  out  W  published angle, modulo 2^W
- frame_tick  out  1  one-cycle pulse on the strobe rising edge

## Operation
- Accumulator acc, W+FRAC bits, unsigned, wraps modulo 2^(W+FRAC); one integer step = 2^FRAC.
- Digital FSM, states IDLE, HOLD, REPEAT; dir = plus XOR minus, sign = plus.
  - IDLE: dir=1 → apply one integer step immediately, load frame counter with DELAY, enter HOLD.
  - HOLD: count frame_ticks; counter hits 0 → one step, reload with (fast ? 1 : RATE), enter REPEAT.
  - REPEAT: counter hits 0 → one step, reload.
  - HOLD or REPEAT with dir=0 → IDLE, no step.
  - Sign change while held (plus↔minus handover through both) → dir=0 for ≥1 cycle → IDLE.
- plus and minus both 1 = dir 0 = no digital motion.
- Spinner path: on any change of spin_in[8] versus its registered copy, sign-extend spin_in[7:0] to W+FRAC bits and add to acc. Deltas span -128..127 and wrap freely.
- Digital step and spinner delta in the same cycle: both are summed into acc in that single cycle.
- angle ← acc[W+FRAC-1:FRAC] only on frame_tick. It holds between ticks.

## Timing
- Reset (reset_n=0 at clk edge): acc=0, angle=0, frame_tick=0, FSM=IDLE, counter=0. Registered strobe and spin_in[8] copies are loaded from the current inputs, so no false edge appears after release.
- frame_tick asserts the cycle after the strobe rising edge is sampled.
- angle is updated at that same edge from the acc value that includes all adds up to the previous cycle.
- Digital step reaches acc 1 cycle after plus/minus is sampled high in IDLE.
- Spinner delta reaches acc 1 cycle after the toggle is seen.
- Latency from input to angle = up to one frame.
- Reset mid-hold: FSM returns to IDLE. If a button is still held after release, it produces an immediate step as a fresh press.

## Configuration
- DIAL_SPIN_INPUT_EN defined: spinner path as above.
- Undefined: spin_in is ignored and the toggle register is removed; only digital motion changes acc.

## Structure
- Package dial_pkg holds:
  - FSM state enum (IDLE, HOLD, REPEAT)
  - spinner word field constants (SPIN_TOGGLE_BIT=8, SPIN_DELTA_MSB=7)
- Sub-module dial_edge: registered rising/any-edge detector. It is instanced for strobe (rising) and for spin_in[8] (any edge).

## Test plan
All scenarios use W=4, FRAC=2, RATE=8, DELAY=16.
- Reset, idle 3 frames → angle=0 every tick, frame_tick one cycle wide per strobe rise.
- plus pulsed 1 cycle, then frame tick → angle=1. Hold plus 16 further frames → one more step (angle=2). Then one step every 8 frames.
- Hold minus with fast=1 from angle=0 → first tick angle=15 (wrap). After DELAY, angle decrements every frame.
- DIAL_SPIN_INPUT_EN: toggle spin_in[8] with delta 8'h06, twice → acc=12, next tick angle=3. Delta 8'h80 from acc=0 → angle=0 (−128 mod 64 = 0).
- plus and minus both high 40 frames → angle constant. Digital step and spinner delta +4 in the same cycle → angle advances by 2 at next tick.
- reset_n low during REPEAT with plus held → angle=0. After release, immediate step → angle=1 at next tick.
